// File: rtl/pad_cond_pkg.sv
// Shared constants and helpers for the input pad conditioning stage.
// Imported by the per-pin filter and the group top.
package pad_cond_pkg;

  localparam int NUM_IN_DEF          = 24;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int FILT_W_DEF          = 4;
  localparam int RST_SYNC_STAGES_DEF = 2;

  // What the per-pin filter does with its conditioned level this cycle
  typedef enum logic [1:0] {
    ACT_FOLLOW,
    ACT_HOLD,
    ACT_COUNT,
    ACT_TAKE
  } filt_act_e;

  // Effective filter length: a programmed 0 behaves like 1
  function automatic int unsigned max1(input int unsigned len);
    return (len == 0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pad_in_filter.sv
// One pin: synchroniser, glitch filter, level and edge outputs.
// Edges are decoded from flops only, never from the pad.
module pad_in_filter
  import pad_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   FILT_W      = FILT_W_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pad,
  input  logic              filt_en,
  input  logic [FILT_W-1:0] filt_len,
  output logic              data,
  output logic              rise,
  output logic              fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   data_d;
  logic                   data_nx;
  logic [FILT_W-1:0]      cnt;
  logic [FILT_W-1:0]      cnt_nx;
  logic                   hit;
  filt_act_e              act;

  assign s   = sync[SYNC_STAGES-1];
  assign hit = (32'(cnt) + 32'd1) >= max1(32'(filt_len));

  // Plain shift chain into the core clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
    end
  end

  // Pick the filter action; bypass wins, then agreement
  always_comb begin
    act = ACT_FOLLOW;
    priority case (1'b1)
      !filt_en:  act = ACT_FOLLOW;
      s == data: act = ACT_HOLD;
      hit:       act = ACT_TAKE;
      default:   act = ACT_COUNT;
    endcase
  end

  // Next level and stability count for the chosen action
  always_comb begin
    data_nx = data;
    cnt_nx  = '0;
    unique case (act)
      ACT_FOLLOW: data_nx = s;
      ACT_TAKE:   data_nx = s;
      ACT_COUNT:  cnt_nx  = cnt + FILT_W'(1);
      default:    cnt_nx  = '0;
    endcase
  end

  // Conditioned level, its delayed copy and the counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= RST_VAL;
      data_d <= RST_VAL;
      cnt    <= '0;
    end else begin
      data   <= data_nx;
      data_d <= data;
      cnt    <= cnt_nx;
    end
  end

  assign rise = data & ~data_d;
  assign fall = ~data & data_d;

endmodule

// File: rtl/pad_in_conditioner.sv
// Input pad group conditioner: per-pin filters, pending/irq,
// and the async-assert / sync-deassert core reset.
module pad_in_conditioner
  import pad_cond_pkg::*;
#(
  parameter int                NUM_IN          = NUM_IN_DEF,
  parameter int                SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int                FILT_W          = FILT_W_DEF,
  parameter int                RST_SYNC_STAGES = RST_SYNC_STAGES_DEF,
  parameter logic [NUM_IN-1:0] SYNC_RST_VAL    = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              rst_n_sync_o,
  input  logic [NUM_IN-1:0] pad_c_i,
  input  logic [NUM_IN-1:0] filt_en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [NUM_IN-1:0] rise_en_i,
  input  logic [NUM_IN-1:0] fall_en_i,
  input  logic [NUM_IN-1:0] irq_mask_i,
  input  logic [NUM_IN-1:0] irq_clr_i,
  output logic [NUM_IN-1:0] data_o,
  output logic [NUM_IN-1:0] rise_o,
  output logic [NUM_IN-1:0] fall_o,
  output logic [NUM_IN-1:0] irq_pend_o,
  output logic              irq_o
);

  logic [RST_SYNC_STAGES-1:0] rst_chain;
  logic [NUM_IN-1:0]          pend;
  logic [NUM_IN-1:0]          set;

  // Reset chain: cleared at once, ones walk in on clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_chain <= '0;
    end else begin
      rst_chain <= {rst_chain[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync_o = rst_chain[RST_SYNC_STAGES-1];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_pin
    pad_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .RST_VAL     (SYNC_RST_VAL[k])
    ) u_filt (
      .clk      (clk),
      .reset_n  (reset_n),
      .pad      (pad_c_i[k]),
      .filt_en  (filt_en_i[k]),
      .filt_len (filt_len_i),
      .data     (data_o[k]),
      .rise     (rise_o[k]),
      .fall     (fall_o[k])
    );
  end

  assign set = (rise_o & rise_en_i) | (fall_o & fall_en_i);

  // Sticky pending bits; a new edge beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~irq_clr_i) | set;
    end
  end

  assign irq_pend_o = pend;
  assign irq_o      = |(pend & irq_mask_i);

endmodule

// File: tb/tb_pad_in_conditioner.sv
// Random plus directed bench for pad_in_conditioner
// against a level/queue reference model.
module tb_pad_in_conditioner;

  localparam int         N   = 8;
  localparam int         SS  = 2;
  localparam int         FW  = 4;
  localparam int         RSS = 2;
  localparam logic [N-1:0] RV = 8'h01;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rst_n_sync;
  logic [N-1:0]  pad_c;
  logic [N-1:0]  filt_en;
  logic [FW-1:0] filt_len;
  logic [N-1:0]  rise_en;
  logic [N-1:0]  fall_en;
  logic [N-1:0]  mask;
  logic [N-1:0]  clr;
  logic [N-1:0]  data;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  pend;
  logic          irq;

  int errors = 0;
  int checks = 0;

  pad_in_conditioner #(
    .NUM_IN          (N),
    .SYNC_STAGES     (SS),
    .FILT_W          (FW),
    .RST_SYNC_STAGES (RSS),
    .SYNC_RST_VAL    (RV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rst_n_sync_o (rst_n_sync),
    .pad_c_i      (pad_c),
    .filt_en_i    (filt_en),
    .filt_len_i   (filt_len),
    .rise_en_i    (rise_en),
    .fall_en_i    (fall_en),
    .irq_mask_i   (mask),
    .irq_clr_i    (clr),
    .data_o       (data),
    .rise_o       (rise),
    .fall_o       (fall),
    .irq_pend_o   (pend),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pad history queue, per-pin differing-run length
  logic [N-1:0] m_data, m_dd, m_pend;
  logic [N-1:0] padq[$];
  int           m_run[N];
  int           m_redges;

  task automatic m_reset();
    m_data = RV;
    m_dd   = RV;
    m_pend = '0;
    for (int k = 0; k < N; k++) m_run[k] = 0;
    padq.delete();
    for (int i = 0; i < SS; i++) padq.push_back(RV);
    m_redges = 0;
  endtask

  task automatic m_edge();
    logic [N-1:0] s, r, f, nd;
    int L;
    s = padq.pop_front();
    padq.push_back(pad_c);
    r = m_data & ~m_dd;
    f = ~m_data & m_dd;
    m_pend = (m_pend & ~clr) | (r & rise_en) | (f & fall_en);
    L = (filt_len == 0) ? 1 : int'(filt_len);
    nd = m_data;
    for (int k = 0; k < N; k++) begin
      if (!filt_en[k]) begin
        nd[k] = s[k];
        m_run[k] = 0;
      end else if (s[k] == m_data[k]) begin
        m_run[k] = 0;
      end else begin
        m_run[k]++;
        if (m_run[k] >= L) begin
          nd[k] = s[k];
          m_run[k] = 0;
        end
      end
    end
    m_dd = m_data;
    m_data = nd;
    if (m_redges < 100) m_redges++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_edge();
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("data_o", 32'(data), 32'(m_data));
    chk("rise_o", 32'(rise), 32'(m_data & ~m_dd));
    chk("fall_o", 32'(fall), 32'(~m_data & m_dd));
    chk("irq_pend_o", 32'(pend), 32'(m_pend));
    chk("irq_o", 32'(irq), 32'(|(m_pend & mask)));
    chk("rst_n_sync_o", 32'(rst_n_sync), 32'(m_redges >= RSS));
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    m_reset();
    pad_c    = 8'h01;
    filt_en  = '0;
    filt_len = 4'd4;
    rise_en  = '0;
    fall_en  = '0;
    mask     = '0;
    clr      = '0;

    repeat (3) begin
      adv(1);
      chk("rst_sync_in_reset", 32'(rst_n_sync), 32'd0);
      chk("data_in_reset", 32'(data), 32'h01);
      chk("edges_in_reset", 32'(rise | fall), 32'd0);
      chk("irq_in_reset", 32'(irq), 32'd0);
    end
    reset_n = 1'b1;
    adv(1);
    chk("rst_sync_1edge", 32'(rst_n_sync), 32'd0);
    adv(1);
    chk("rst_sync_2edge", 32'(rst_n_sync), 32'd1);
    chk("no_fall_idle_high", 32'(fall), 32'd0);

    rise_en = 8'h02;
    mask    = 8'h02;
    pad_c[1] = 1'b1;
    adv(2);
    chk("p1_lat2", 32'(data[1]), 32'd0);
    adv(1);
    chk("p1_lat3", 32'(data[1]), 32'd1);
    chk("p1_rise", 32'(rise[1]), 32'd1);
    chk("p1_pend_early", 32'(pend[1]), 32'd0);
    adv(1);
    chk("p1_rise_gone", 32'(rise[1]), 32'd0);
    chk("p1_pend", 32'(pend[1]), 32'd1);
    chk("p1_irq", 32'(irq), 32'd1);
    clr = 8'h02;
    adv(1);
    clr = '0;
    chk("p1_cleared", 32'(pend[1]), 32'd0);

    filt_en  = 8'h20;
    filt_len = 4'd4;
    pad_c[5] = 1'b1;
    adv(3);
    pad_c[5] = 1'b0;
    adv(8);
    chk("p5_short_pulse", 32'(data[5]), 32'd0);
    pad_c[5] = 1'b1;
    adv(5);
    chk("p5_lat5", 32'(data[5]), 32'd0);
    adv(1);
    chk("p5_lat6", 32'(data[5]), 32'd1);

    rise_en = 8'h04;
    mask    = 8'h04;
    pad_c[2] = 1'b1;
    adv(3);
    chk("p2_rise", 32'(rise[2]), 32'd1);
    clr = 8'h04;
    adv(1);
    chk("p2_set_beats_clr", 32'(pend[2]), 32'd1);
    adv(1);
    clr = '0;
    chk("p2_clr_alone", 32'(pend[2]), 32'd0);
    chk("p2_irq_low", 32'(irq), 32'd0);

    rise_en = 8'h80;
    mask    = 8'h00;
    pad_c[7] = 1'b1;
    adv(4);
    chk("p7_pend", 32'(pend[7]), 32'd1);
    chk("p7_masked", 32'(irq), 32'd0);
    mask = 8'h80;
    #1;
    chk("p7_unmask_same", 32'(irq), 32'd1);

    rise_en  = '0;
    fall_en  = 8'h01;
    filt_en  = 8'h21;
    filt_len = 4'd0;
    pad_c[0] = 1'b0;
    adv(2);
    chk("p0_len0_lat2", 32'(data[0]), 32'd1);
    adv(1);
    chk("p0_len0_lat3", 32'(data[0]), 32'd0);
    chk("p0_fall", 32'(fall[0]), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 5) == 0) pad_c[k] = ~pad_c[k];
      if ($urandom_range(0, 40) == 0) filt_en = 8'($urandom);
      if ($urandom_range(0, 60) == 0) filt_len = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 30) == 0) rise_en = 8'($urandom);
      if ($urandom_range(0, 30) == 0) fall_en = 8'($urandom);
      if ($urandom_range(0, 20) == 0) mask = 8'($urandom);
      clr = 8'($urandom & $urandom & $urandom);
      if (i == 1500) begin
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      adv(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
